// File: rtl/eth_dump_sequencer_if.sv
// FIFO-pop and UART-transmit signal bundle for eth_dump_sequencer.
// master = sequencer side, slave = FIFO/UART side.
interface eth_dump_sequencer_if;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [9:0] fifo_rd_data;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;

    modport master (
        input  fifo_empty, fifo_rd_data, tx_busy,
        output fifo_rd_en, tx_data, tx_start
    );

    modport slave (
        output fifo_empty, fifo_rd_data, tx_busy,
        input  fifo_rd_en, tx_data, tx_start
    );
endinterface

// File: rtl/eth_dump_sequencer.sv
// Pops framed words from a FIFO and dumps them byte-wise to a UART with SOF/EOF markers and a byte count.
// Define ETH_DUMP_HEX_EN to emit data and count bytes as two uppercase ASCII hex characters.
module eth_dump_sequencer #(
    parameter logic [7:0]  SOF_BYTE  = 8'hA5,
    parameter logic [7:0]  EOF_BYTE  = 8'h5A,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    eth_dump_sequencer_if.master bus,
    output logic                 busy,
    output logic [15:0]          frames_dumped,
    output logic                 frame_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_POP, S_LATCH, S_SEND, S_WAIT_HI, S_WAIT_LO
    } state_e;

    typedef enum logic [2:0] {
        IT_SOF, IT_DATA, IT_EOF, IT_CNT_HI, IT_CNT_LO
    } item_e;

`ifdef ETH_DUMP_HEX_EN
    localparam logic HEX_EN = 1'b1;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction
`else
    localparam logic HEX_EN = 1'b0;
`endif

    state_e               state_q, state_d;
    item_e                item_q, item_d;
    logic                 nib_q, nib_d;
    logic [8:0]           word_q, word_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 open_q, open_d;
    logic                 restart_q, restart_d;
    logic [15:0]          frames_q, frames_d;
    logic [7:0]           txd_q, txd_d;

    logic [15:0]          cnt16;
    logic [7:0]           raw_b;
    logic [7:0]           byte_cur;
    logic                 two_char;

    assign cnt16 = 16'(cnt_q);

    always_comb begin
        raw_b = '0;
        case (item_q)
            IT_DATA:   raw_b = word_q[7:0];
            IT_CNT_HI: raw_b = cnt16[15:8];
            IT_CNT_LO: raw_b = cnt16[7:0];
            default:   raw_b = '0;
        endcase

        byte_cur = raw_b;
        if (item_q == IT_SOF) begin
            byte_cur = SOF_BYTE;
        end else if (item_q == IT_EOF) begin
            byte_cur = EOF_BYTE;
        end else begin
`ifdef ETH_DUMP_HEX_EN
            byte_cur = hex_char(nib_q ? raw_b[3:0] : raw_b[7:4]);
`else
            byte_cur = raw_b;
`endif
        end
    end

    assign two_char     = HEX_EN && (item_q inside {IT_DATA, IT_CNT_HI, IT_CNT_LO});
    // In SEND the byte is driven live so it is valid on the tx_start cycle; it is held in txd_q afterwards.
    assign bus.tx_data  = (state_q == S_SEND) ? byte_cur : txd_q;
    assign busy         = (state_q != S_IDLE);
    assign frames_dumped = frames_q;

    always_comb begin
        state_d        = state_q;
        item_d         = item_q;
        nib_d          = nib_q;
        word_d         = word_q;
        cnt_d          = cnt_q;
        open_d         = open_q;
        restart_d      = restart_q;
        frames_d       = frames_q;
        txd_d          = txd_q;
        bus.fifo_rd_en = 1'b0;
        bus.tx_start   = 1'b0;
        frame_err      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bus.fifo_empty) state_d = S_POP;
            end
            S_POP: begin
                bus.fifo_rd_en = 1'b1;
                state_d        = S_LATCH;
            end
            S_LATCH: begin
                word_d = bus.fifo_rd_data[8:0];
                nib_d  = 1'b0;
                if (!bus.fifo_rd_data[9] && !open_q) begin
                    frame_err = 1'b1;
                    state_d   = S_IDLE;
                end else if (bus.fifo_rd_data[9] && open_q) begin
                    // Close the truncated frame first; the new word restarts after its count.
                    frame_err = 1'b1;
                    restart_d = 1'b1;
                    item_d    = IT_EOF;
                    state_d   = S_SEND;
                end else if (bus.fifo_rd_data[9]) begin
                    cnt_d   = CNT_WIDTH'(1);
                    open_d  = 1'b1;
                    item_d  = IT_SOF;
                    state_d = S_SEND;
                end else begin
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                    item_d  = IT_DATA;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!bus.tx_busy) begin
                    bus.tx_start = 1'b1;
                    txd_d        = byte_cur;
                    state_d      = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (bus.tx_busy) state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    state_d = S_SEND;
                    if (two_char && !nib_q) begin
                        nib_d = 1'b1;
                    end else begin
                        nib_d = 1'b0;
                        case (item_q)
                            IT_SOF:    item_d = IT_DATA;
                            IT_DATA: begin
                                if (word_q[8]) item_d = IT_EOF;
                                else           state_d = S_IDLE;
                            end
                            IT_EOF:    item_d = IT_CNT_HI;
                            IT_CNT_HI: item_d = IT_CNT_LO;
                            IT_CNT_LO: begin
                                frames_d = frames_q + 16'd1;
                                open_d   = 1'b0;
                                if (restart_q) begin
                                    restart_d = 1'b0;
                                    cnt_d     = CNT_WIDTH'(1);
                                    open_d    = 1'b1;
                                    item_d    = IT_SOF;
                                end else begin
                                    state_d = S_IDLE;
                                end
                            end
                            default:   state_d = S_IDLE;
                        endcase
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            item_q    <= IT_SOF;
            nib_q     <= 1'b0;
            word_q    <= '0;
            cnt_q     <= '0;
            open_q    <= 1'b0;
            restart_q <= 1'b0;
            frames_q  <= '0;
            txd_q     <= '0;
        end else begin
            state_q   <= state_d;
            item_q    <= item_d;
            nib_q     <= nib_d;
            word_q    <= word_d;
            cnt_q     <= cnt_d;
            open_q    <= open_d;
            restart_q <= restart_d;
            frames_q  <= frames_d;
            txd_q     <= txd_d;
        end
    end

endmodule

// File: tb/tb_eth_dump_sequencer.sv
// Self-checking bench for eth_dump_sequencer: FIFO and UART models, vector table, corner sequences, random frames.
// Honours ETH_DUMP_HEX_EN when compiled with it.
module tb_eth_dump_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy;
    logic        frame_err;
    logic [15:0] frames_dumped;

    eth_dump_sequencer_if bus ();

    eth_dump_sequencer #(
        .SOF_BYTE (8'hA5),
        .EOF_BYTE (8'h5A),
        .CNT_WIDTH(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .frames_dumped(frames_dumped),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    // FIFO model: initial block owns wr_ptr/fmem, the always block owns rd_ptr and outputs
    logic [9:0] fmem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       fifo_empty_r = 1'b1;
    logic [9:0] fifo_rd_data_r = '0;

    // UART model and monitors
    int         ucnt = 0;
    logic       uart_busy;
    logic       hold_busy = 1'b0;
    logic [7:0] got [$];
    logic [7:0] last_b = '0;
    int         err_cnt = 0;
    int         rd_cnt = 0;
    int         rd_viol = 0;
    int         stab_err = 0;

    assign uart_busy        = (ucnt != 0) && (ucnt <= 10);
    assign bus.tx_busy      = uart_busy | hold_busy;
    assign bus.fifo_empty   = fifo_empty_r;
    assign bus.fifo_rd_data = fifo_rd_data_r;

    always @(negedge clk) begin
        if (bus.fifo_rd_en && rd_ptr != wr_ptr) begin
            fifo_rd_data_r <= fmem[rd_ptr % 256];
            rd_ptr         <= rd_ptr + 1;
            fifo_empty_r   <= ((rd_ptr + 1) == wr_ptr);
        end else begin
            fifo_empty_r   <= (rd_ptr == wr_ptr);
        end
    end

    always @(negedge clk) begin
        if (bus.tx_start) begin
            got.push_back(bus.tx_data);
            last_b <= bus.tx_data;
            ucnt   <= 11;
        end else if (ucnt != 0) begin
            ucnt <= ucnt - 1;
        end
        if (uart_busy && busy && bus.tx_data != last_b) stab_err <= stab_err + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
        if (bus.fifo_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (fifo_empty_r) rd_viol <= rd_viol + 1;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference model: frame rules applied word by word
    logic [7:0] exp [$];
    logic       m_open = 1'b0;
    int         m_cnt = 0;
    int         m_err = 0;
    int         m_frames = 0;

    function automatic logic [7:0] hexc(input int v);
        return (v < 10) ? 8'(48 + v) : 8'(65 + v - 10);
    endfunction

    task automatic emit_val(input int v);
`ifdef ETH_DUMP_HEX_EN
        exp.push_back(hexc(v / 16));
        exp.push_back(hexc(v % 16));
`else
        exp.push_back(8'(v));
`endif
    endtask

    task automatic emit_close();
        exp.push_back(8'h5A);
        emit_val(m_cnt / 256);
        emit_val(m_cnt % 256);
        m_frames++;
        m_open = 1'b0;
    endtask

    task automatic model_word(input logic [9:0] w);
        if (!w[9] && !m_open) begin
            m_err++;
            return;
        end
        if (w[9] && m_open) begin
            m_err++;
            emit_close();
        end
        if (w[9]) begin
            exp.push_back(8'hA5);
            m_cnt  = 1;
            m_open = 1'b1;
        end else if (m_cnt < 65535) begin
            m_cnt++;
        end
        emit_val(int'(w[7:0]));
        if (w[8]) emit_close();
    endtask

    task automatic push_word(input logic [9:0] w);
        fmem[wr_ptr % 256] = w;
        wr_ptr++;
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst       = 1'b1;
        hold_busy = 1'b0;
        wr_ptr    = rd_ptr;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_open = 1'b0; m_cnt = 0; m_err = 0; m_frames = 0;
        exp.delete();
    endtask

    task automatic wait_idle(input string name, input int limit);
        int stable = 0;
        int n = 0;
        while (stable < 3 && n < limit) begin
            @(posedge clk); #1;
            n++;
            if (!busy && fifo_empty_r && rd_ptr == wr_ptr && ucnt == 0) stable++;
            else stable = 0;
        end
        if (stable < 3) begin
            total++;
            bad++;
            $display("FAIL %s: idle not reached within %0d cycles", name, limit);
        end
    endtask

    task automatic compare_stream(input string name, input int gs);
        check({name, "_len"}, got.size() - gs, exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (gs + i < got.size())
                check($sformatf("%s_byte%0d", name, i), got[gs + i], exp[i]);
        end
    endtask

    typedef struct {
        string        name;
        int           nw;
        logic [39:0]  w;
        int           nb;
        logic [127:0] b;
        int           err;
        int           frames;
        int           rd;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int gs, e0, r0, n, nst;
        logic [9:0] w;

        tbl[0] = '{"single", 1, 40'h342, 0, '0, 0, 1, 1};
        tbl[1] = '{"three", 3, {10'h201, 10'h002, 10'h103}, 0, '0, 0, 1, 3};
        tbl[2] = '{"orphan", 1, 40'h077, 0, '0, 1, 0, 1};
        tbl[3] = '{"restart", 2, {10'h210, 10'h320}, 0, '0, 1, 2, 2};
`ifdef ETH_DUMP_HEX_EN
        tbl[0].nb = 8;  tbl[0].b = 128'hA5_34_32_5A_30_30_30_31;
        tbl[1].nb = 12; tbl[1].b = 128'hA5_30_31_30_32_30_33_5A_30_30_30_33;
        tbl[3].nb = 16; tbl[3].b = 128'hA5_31_30_5A_30_30_30_31_A5_32_30_5A_30_30_30_31;
`else
        tbl[0].nb = 5;  tbl[0].b = 128'hA5_42_5A_00_01;
        tbl[1].nb = 7;  tbl[1].b = 128'hA5_01_02_03_5A_00_03;
        tbl[3].nb = 10; tbl[3].b = 128'hA5_10_5A_00_01_A5_20_5A_00_01;
`endif

        // Reset state
        reset_dut();
        check("rst_fifo_rd_en", bus.fifo_rd_en, 0);
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_frames_dumped", frames_dumped, 0);

        // SOF latency from fifo_empty falling
        push_word(10'h342);
        @(negedge clk); #1;
        check("lat_fifo_nonempty", fifo_empty_r, 0);
        n = 0;
        while (!bus.tx_start && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("lat_sof_cycles", n, 3);
        check("lat_sof_byte", bus.tx_data, 8'hA5);
        wait_idle("lat", 2000);
        check("lat_frames", frames_dumped, 1);

        // Vector table
        for (int t = 0; t < 4; t++) begin
            reset_dut();
            gs = got.size(); e0 = err_cnt; r0 = rd_cnt;
            for (int i = 0; i < tbl[t].nw; i++) push_word(tbl[t].w[10*(tbl[t].nw-1-i) +: 10]);
            wait_idle(tbl[t].name, 3000);
            check({tbl[t].name, "_len"}, got.size() - gs, tbl[t].nb);
            for (int i = 0; i < tbl[t].nb; i++) begin
                if (gs + i < got.size())
                    check($sformatf("%s_byte%0d", tbl[t].name, i), got[gs + i],
                          tbl[t].b[8*(tbl[t].nb-1-i) +: 8]);
            end
            check({tbl[t].name, "_err"}, err_cnt - e0, tbl[t].err);
            check({tbl[t].name, "_frames"}, frames_dumped, tbl[t].frames);
            check({tbl[t].name, "_rd"}, rd_cnt - r0, tbl[t].rd);
        end

        // UART held busy: no strobe, no second pop, nothing lost
        reset_dut();
        hold_busy = 1'b1;
        gs = got.size(); r0 = rd_cnt;
        model_word(10'h233); model_word(10'h144);
        push_word(10'h233); push_word(10'h144);
        nst = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (bus.tx_start) nst++;
        end
        check("hold_tx_start", nst, 0);
        check("hold_rd_once", rd_cnt - r0, 1);
        check("hold_busy_flag", busy, 1);
        hold_busy = 1'b0;
        wait_idle("hold", 3000);
        compare_stream("hold", gs);
        check("hold_rd_total", rd_cnt - r0, 2);
        check("hold_frames", frames_dumped, m_frames);

        // Reset mid-frame discards the open frame
        reset_dut();
        push_word(10'h255); push_word(10'h066);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        wr_ptr = rd_ptr;
        @(posedge clk); #1;
        check("midrst_busy", busy, 0);
        check("midrst_frames", frames_dumped, 0);
        check("midrst_tx_data", bus.tx_data, 0);
        rst = 1'b0;
        wait_idle("midrst_drain", 2000);
        m_open = 1'b0; m_cnt = 0; m_err = 0; m_frames = 0; exp.delete();
        gs = got.size(); e0 = err_cnt;
        push_word(10'h066);
        wait_idle("midrst_orphan", 2000);
        check("midrst_orphan_err", err_cnt - e0, 1);
        check("midrst_orphan_bytes", got.size() - gs, 0);

        // Random frames against the model
        reset_dut();
        gs = got.size(); e0 = err_cnt; r0 = rd_cnt;
        for (int i = 0; i < 60; i++) begin
            w = {($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), 8'($urandom)};
            model_word(w);
            push_word(w);
        end
        wait_idle("rand", 20000);
        compare_stream("rand", gs);
        check("rand_err", err_cnt - e0, m_err);
        check("rand_frames", frames_dumped, m_frames);
        check("rand_rd", rd_cnt - r0, 60);

        check("rd_while_empty", rd_viol, 0);
        check("tx_data_stable", stab_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
